alu_math_mc: RTL and testbench

ALU_MATH_MC -- requirements
Module: alu_math_mc

---
 rtl/alu_math_mc.sv | 212 +++++++++++++++++++++
 tb/tb_alu_math_mc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_math_mc.sv
// alu_math_mc: valid/ready ALU with 1-cycle ADD/ADDI/SUB and an iterative shift-add MUL.
// Optional feature macro ALU_MATH_MC_MUL_EN enables the multiplier; when it is undefined, op 11 is reported as illegal.
module alu_math_mc #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IMM_WIDTH  = 6
) (
   input  logic                  clk_i,
   input  logic                  arst_ni,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [1:0]            op_i,
   input  logic [DATA_WIDTH-1:0] rs1_data_i,
   input  logic [DATA_WIDTH-1:0] rs2_data_i,
   input  logic [IMM_WIDTH-1:0]  imm_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  carry_o,
   output logic                  ovf_o,
   output logic                  illegal_o
);

   localparam int unsigned MSB   = DATA_WIDTH - 1;
   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_ADDI = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_MUL  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic r_arm;
   logic w_accept;
   logic w_is_mul;
   logic w_go_busy;
   logic w_mul_last;

   logic [DATA_WIDTH-1:0] w_imm_ext;
   logic [DATA_WIDTH-1:0] w_opb;
   logic                  w_cin;
   logic [DATA_WIDTH:0]   w_sum;
   logic                  w_ovf;

   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_carry;
   logic                  r_ovf;
   logic                  r_illegal;

   assign w_is_mul = (op_i == OP_MUL);

   // Blocks acceptance on the first edge after reset release
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_arm <= 1'b0;
      end else begin
         r_arm <= 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_go_busy ? S_BUSY : S_DONE;
            end
         end
         S_BUSY: begin
            if (w_mul_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (w_accept) begin
               w_state_nxt = w_go_busy ? S_BUSY : S_DONE;
            end else if (ready_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      ready_o = 1'b0;
      valid_o = 1'b0;
      case (r_state)
         S_IDLE: ready_o = 1'b1;
         S_DONE: begin
            ready_o = ready_i;
            valid_o = 1'b1;
         end
         default: begin
            ready_o = 1'b0;
            valid_o = 1'b0;
         end
      endcase
      w_accept = valid_i && ready_o && r_arm;
   end

   // Single-cycle adder shared by ADD, ADDI and SUB
   always_comb begin
      w_imm_ext = DATA_WIDTH'($signed(imm_i));
      w_opb     = rs2_data_i;
      w_cin     = 1'b0;
      case (op_i)
         OP_ADD:  w_opb = rs2_data_i;
         OP_ADDI: w_opb = w_imm_ext;
         OP_SUB: begin
            w_opb = ~rs2_data_i;
            w_cin = 1'b1;
         end
         default: w_opb = rs2_data_i;
      endcase
      w_sum = {1'b0, rs1_data_i} + {1'b0, w_opb} + (DATA_WIDTH+1)'(w_cin);
      w_ovf = (rs1_data_i[MSB] == w_opb[MSB]) && (w_sum[MSB] != rs1_data_i[MSB]);
   end

`ifdef ALU_MATH_MC_MUL_EN
   logic [CNT_W-1:0]        r_cnt;
   logic [DATA_WIDTH-1:0]   r_mcand;
   logic [2*DATA_WIDTH-1:0] r_prod;
   logic [2*DATA_WIDTH-1:0] w_prod_nxt;
   logic [DATA_WIDTH:0]     w_psum;

   assign w_go_busy  = w_is_mul;
   assign w_mul_last = (r_state == S_BUSY) && (r_cnt == CNT_W'(DATA_WIDTH - 1));

   // One multiplier bit per step: add multiplicand to the high half, shift right
   always_comb begin
      w_psum = {1'b0, r_prod[2*DATA_WIDTH-1:DATA_WIDTH]};
      if (r_prod[0]) begin
         w_psum = w_psum + {1'b0, r_mcand};
      end
      w_prod_nxt = {w_psum, r_prod[DATA_WIDTH-1:1]};
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_cnt   <= '0;
         r_mcand <= '0;
         r_prod  <= '0;
      end else if (w_accept && w_is_mul) begin
         r_cnt   <= '0;
         r_mcand <= rs1_data_i;
         r_prod  <= {DATA_WIDTH'(0), rs2_data_i};
      end else if (r_state == S_BUSY) begin
         r_prod <= w_prod_nxt;
         if (!w_mul_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign w_go_busy  = 1'b0;
   assign w_mul_last = 1'b0;
`endif

   // Result and flag registers; held while waiting for the consumer
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_result  <= '0;
         r_carry   <= 1'b0;
         r_ovf     <= 1'b0;
         r_illegal <= 1'b0;
      end else if (w_accept && !w_go_busy) begin
         if (w_is_mul) begin
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b1;
         end else begin
            r_result  <= w_sum[DATA_WIDTH-1:0];
            r_carry   <= w_sum[DATA_WIDTH];
            r_ovf     <= w_ovf;
            r_illegal <= 1'b0;
         end
`ifdef ALU_MATH_MC_MUL_EN
      end else if (w_mul_last) begin
         r_result  <= w_prod_nxt[DATA_WIDTH-1:0];
         r_carry   <= 1'b0;
         r_ovf     <= |w_prod_nxt[2*DATA_WIDTH-1:DATA_WIDTH];
         r_illegal <= 1'b0;
`endif
      end
   end

   assign result_o  = r_result;
   assign carry_o   = r_carry;
   assign ovf_o     = r_ovf;
   assign illegal_o = r_illegal;

endmodule

// File: tb/tb_alu_math_mc.sv
// tb_alu_math_mc: directed corner cases plus randomized ops against a transaction-level model.
module tb_alu_math_mc;

   localparam int unsigned DW = 32;
   localparam int unsigned IW = 6;
`ifdef ALU_MATH_MC_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          arst_ni;
   logic          valid_i;
   logic          ready_o;
   logic [1:0]    op_i;
   logic [DW-1:0] rs1_data_i;
   logic [DW-1:0] rs2_data_i;
   logic [IW-1:0] imm_i;
   logic          valid_o;
   logic          ready_i;
   logic [DW-1:0] result_o;
   logic          carry_o;
   logic          ovf_o;
   logic          illegal_o;

   int n_total = 0;
   int n_bad   = 0;

   alu_math_mc #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) u_dut (
      .clk_i      (clk_i),
      .arst_ni    (arst_ni),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .op_i       (op_i),
      .rs1_data_i (rs1_data_i),
      .rs2_data_i (rs2_data_i),
      .imm_i      (imm_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .result_o   (result_o),
      .carry_o    (carry_o),
      .ovf_o      (ovf_o),
      .illegal_o  (illegal_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: {illegal, ovf, carry, result} from plain integer arithmetic
   function automatic logic [DW+2:0] ref_op(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [IW-1:0] imm);
      longint          sa, sb, ts, smax, smin;
      longint unsigned ua, ub, us, mask;
      logic            ill, ovf, cy;
      logic [DW-1:0]   res;
      mask = (64'd1 << DW) - 64'd1;
      smax = (64'sd1 <<< (DW - 1)) - 64'sd1;
      smin = -(64'sd1 <<< (DW - 1));
      sa   = longint'($signed(a));
      ua   = 64'(a);
      sb   = 0;
      ub   = 0;
      ill  = 1'b0;
      ovf  = 1'b0;
      cy   = 1'b0;
      res  = '0;
      if (op == 2'b11) begin
         if (MUL_ON) begin
            us  = ua * 64'(b);
            res = us[DW-1:0];
            ovf = (us >> DW) != 64'd0;
         end else begin
            ill = 1'b1;
         end
      end else begin
         case (op)
            2'b00: begin sb = longint'($signed(b)); ub = 64'(b); end
            2'b01: begin sb = longint'($signed(imm)); ub = 64'(sb) & mask; end
            default: begin sb = -longint'($signed(b)); ub = (mask - 64'(b)) + 64'd1; end
         endcase
         us  = ua + ub;
         res = us[DW-1:0];
         cy  = us[DW];
         ts  = sa + sb;
         ovf = (ts > smax) || (ts < smin);
      end
      return {ill, ovf, cy, res};
   endfunction

   function automatic logic [DW-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return DW'($urandom_range(0, 15));
         default: return DW'($urandom);
      endcase
   endfunction

   // Issue one op from IDLE with ready_i high; report latency and whether ready_o rose while busy
   task automatic run_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [IW-1:0] imm, output int lat, output bit busy_rdy);
      @(negedge clk_i);
      valid_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; imm_i = imm; ready_i = 1'b1;
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      lat = 0;
      busy_rdy = 1'b0;
      while (lat < 60) begin
         @(negedge clk_i);
         lat++;
         if (valid_o) break;
         if (ready_o) busy_rdy = 1'b1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int             lat;
      bit             brdy;
      bit             m_has;
      int             m_wait;
      bit             exp_valid;
      bit             exp_ready;
      logic [DW+2:0]  m_exp;

      arst_ni = 1'b0; valid_i = 1'b0; op_i = 2'b00; rs1_data_i = '0; rs2_data_i = '0;
      imm_i = '0; ready_i = 1'b0;
      #12;
      check("rst_valid", valid_o, 0);
      check("rst_ready", ready_o, 1);
      check("rst_out", {illegal_o, ovf_o, carry_o, result_o}, 0);

      // Valid held through release: the first edge must not accept
      @(negedge clk_i);
      arst_ni = 1'b1; valid_i = 1'b1; op_i = 2'b00; rs1_data_i = 2; rs2_data_i = 3; ready_i = 1'b1;
      @(negedge clk_i);
      check("first_edge_ignored", valid_o, 0);
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      @(negedge clk_i);
      check("second_edge_valid", valid_o, 1);
      check("second_edge_res", result_o, 5);

      run_op(2'b00, 32'hFFFF_FFFF, 32'h1, '0, lat, brdy);
      check("add_lat", lat, 1);
      check("add_wrap", {illegal_o, ovf_o, carry_o, result_o}, {1'b0, 1'b0, 1'b1, 32'h0});

      run_op(2'b10, 32'h8000_0000, 32'h1, '0, lat, brdy);
      check("sub_lat", lat, 1);
      check("sub_ovf", {illegal_o, ovf_o, carry_o, result_o}, {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF});

      run_op(2'b01, 32'd5, 32'h0, 6'b111111, lat, brdy);
      check("addi_lat", lat, 1);
      check("addi_neg", {illegal_o, ovf_o, carry_o, result_o}, {1'b0, 1'b0, 1'b1, 32'd4});

      run_op(2'b11, 32'd7, 32'd6, '0, lat, brdy);
      if (MUL_ON) begin
         check("mul_lat", lat, 33);
         check("mul_busy_ready", brdy, 0);
         check("mul_7x6", {illegal_o, ovf_o, carry_o, result_o}, {1'b0, 1'b0, 1'b0, 32'd42});
      end else begin
         check("mul_off_lat", lat, 1);
         check("mul_off", {illegal_o, ovf_o, carry_o, result_o}, {1'b1, 1'b0, 1'b0, 32'd0});
      end

      run_op(2'b11, 32'h1_0000, 32'h1_0000, '0, lat, brdy);
      if (MUL_ON) begin
         check("mul_big", {illegal_o, ovf_o, carry_o, result_o}, {1'b0, 1'b1, 1'b0, 32'd0});
      end else begin
         check("mul_off_big", {illegal_o, ovf_o, carry_o, result_o}, {1'b1, 1'b0, 1'b0, 32'd0});
      end

      // Backpressure: result held for 3 cycles, then back-to-back accept
      @(negedge clk_i);
      valid_i = 1'b1; op_i = 2'b00; rs1_data_i = 10; rs2_data_i = 20; ready_i = 1'b0;
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("bp_valid", valid_o, 1);
         check("bp_hold", {illegal_o, ovf_o, carry_o, result_o}, {1'b0, 1'b0, 1'b0, 32'd30});
         check("bp_ready", ready_o, 0);
      end
      @(negedge clk_i);
      valid_i = 1'b1; op_i = 2'b00; rs1_data_i = 100; rs2_data_i = 1; ready_i = 1'b1;
      #1 check("b2b_ready", ready_o, 1);
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      @(negedge clk_i);
      check("b2b_valid", valid_o, 1);
      check("b2b_res", result_o, 101);

      // Reset in the middle of a MUL
      @(negedge clk_i);
      valid_i = 1'b1; op_i = 2'b11; rs1_data_i = 7; rs2_data_i = 6; ready_i = 1'b0;
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      repeat (10) @(negedge clk_i);
      check("mid_mul_ready", ready_o, 0);
      check("mid_mul_valid", valid_o, MUL_ON ? 0 : 1);
      #2 arst_ni = 1'b0;
      #1;
      check("rst_mid_valid", valid_o, 0);
      check("rst_mid_ready", ready_o, 1);
      check("rst_mid_out", {illegal_o, ovf_o, carry_o, result_o}, 0);
      @(negedge clk_i);
      arst_ni = 1'b1; ready_i = 1'b1;
      run_op(2'b00, 32'd2, 32'd3, '0, lat, brdy);
      check("post_rst_lat", lat, 1);
      check("post_rst_add", {illegal_o, ovf_o, carry_o, result_o}, {1'b0, 1'b0, 1'b0, 32'd5});

      // Random traffic with random consumer backpressure
      m_has  = 1'b0;
      m_wait = 0;
      m_exp  = '0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(negedge clk_i);
         exp_valid = m_has && (m_wait == 0);
         check("rnd_valid", valid_o, exp_valid);
         if (exp_valid) begin
            check("rnd_out", {illegal_o, ovf_o, carry_o, result_o}, m_exp);
         end
         valid_i    = 1'($urandom_range(0, 1));
         op_i       = 2'($urandom_range(0, 3));
         rs1_data_i = pick();
         rs2_data_i = pick();
         imm_i      = IW'($urandom);
         ready_i    = ($urandom_range(0, 3) != 0);
         #1;
         exp_ready = !m_has || ((m_wait == 0) && ready_i);
         check("rnd_ready", ready_o, exp_ready);
         if (exp_valid && ready_i) begin
            m_has = 1'b0;
         end else if (m_has && (m_wait > 0)) begin
            m_wait--;
         end
         if (valid_i && exp_ready) begin
            m_has  = 1'b1;
            m_exp  = ref_op(op_i, rs1_data_i, rs2_data_i, imm_i);
            m_wait = ((op_i == 2'b11) && MUL_ON) ? int'(DW) : 0;
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
